order_msg_parser: RTL and testbench

ORDER_MSG_PARSER -- requirements
Module: order_msg_parser

---
 rtl/order_msg_parser.sv | 138 +++++++++++++
 tb/tb_order_msg_parser.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/order_msg_parser.sv
// order_msg_parser: accepts fixed 8-byte order messages from a byte stream,
// dispatches add/cancel requests downstream and waits for completion.
module order_msg_parser #(
    parameter logic [7:0]  ADD_TYPE = 8'h41,
    parameter logic [7:0]  CXL_TYPE = 8'h58,
    parameter logic [15:0] WAIT_MAX = 16'd1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] ord_id,
    output logic        ord_side,
    output logic [15:0] ord_price,
    output logic [15:0] ord_qty,
    output logic        add_start,
    output logic        cxl_start,
    input  logic        done_in,
    output logic [15:0] msg_count,
    output logic [15:0] err_count,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, COLLECT, DROP, DISPATCH, WAIT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  byte_cnt;
    logic [15:0] timer;
    logic        is_add;
    logic [15:0] sh_id, sh_price;
    logic        sh_side;
    logic [7:0]  sh_qty_hi;

    logic xfer, last_byte, wait_tmo, msg_inc, err_inc;

    // Ready is gated by rst_n so no byte is taken while reset is held.
    assign in_ready  = rst_n && (state == IDLE || state == COLLECT || state == DROP);
    assign xfer      = in_valid && in_ready;
    assign last_byte = xfer && (byte_cnt == 3'd7);
    assign busy      = (state != IDLE);
    // done_in wins over a same-cycle timeout.
    assign wait_tmo  = (state == WAIT) && !done_in && (timer >= WAIT_MAX);
    assign msg_inc   = (state == DISPATCH);
    assign err_inc   = ((state == DROP) && last_byte) || wait_tmo;

    // Next-state and start pulses.
    always_comb begin
        state_nxt = state;
        add_start = 1'b0;
        cxl_start = 1'b0;
        case (state)
            IDLE: begin
                if (xfer)
                    state_nxt = (in_data == ADD_TYPE || in_data == CXL_TYPE) ? COLLECT : DROP;
            end
            COLLECT: begin
                if (last_byte) state_nxt = DISPATCH;
            end
            DROP: begin
                if (last_byte) state_nxt = IDLE;
            end
            DISPATCH: begin
                add_start = is_add;
                cxl_start = !is_add;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_in || timer >= WAIT_MAX) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Byte counter, shadow field assembly and the copy into ord_* at byte7.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt  <= 3'd0;
            is_add    <= 1'b0;
            sh_id     <= 16'd0;
            sh_side   <= 1'b0;
            sh_price  <= 16'd0;
            sh_qty_hi <= 8'd0;
            ord_id    <= 16'd0;
            ord_side  <= 1'b0;
            ord_price <= 16'd0;
            ord_qty   <= 16'd0;
        end else if (xfer) begin
            // 3-bit counter naturally wraps 7->0 on the final byte.
            byte_cnt <= byte_cnt + 3'd1;
            if (state == IDLE)
                is_add <= (in_data == ADD_TYPE);
            if (state == COLLECT) begin
                case (byte_cnt)
                    3'd1: sh_id[15:8]    <= in_data;
                    3'd2: sh_id[7:0]     <= in_data;
                    3'd3: sh_side        <= in_data[0];
                    3'd4: sh_price[15:8] <= in_data;
                    3'd5: sh_price[7:0]  <= in_data;
                    3'd6: sh_qty_hi      <= in_data;
                    3'd7: begin
                        ord_id    <= sh_id;
                        ord_side  <= sh_side;
                        ord_price <= sh_price;
                        ord_qty   <= {sh_qty_hi, in_data};
                    end
                    default: ;
                endcase
            end
        end
    end

    // WAIT timer: holds the 1-based index of the current WAIT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)                                    timer <= 16'd0;
        else if (state == DISPATCH)                    timer <= 16'd1;
        else if (state == WAIT && state_nxt == WAIT)   timer <= timer + 16'd1;
        else                                           timer <= 16'd0;
    end

    // Saturating message and error counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_count <= 16'd0;
            err_count <= 16'd0;
        end else begin
            if (msg_inc && msg_count != 16'hFFFF) msg_count <= msg_count + 16'd1;
            if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_order_msg_parser.sv
// Self-checking bench for order_msg_parser: directed scenarios plus random
// messages checked against a message-level reference model.
module tb_order_msg_parser;

    localparam int WMAX = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        done_in = 1'b0;
    logic        in_ready, ord_side, add_start, cxl_start, busy;
    logic [15:0] ord_id, ord_price, ord_qty, msg_count, err_count;

    int chk = 0, fail = 0;
    int add_cnt = 0, cxl_cnt = 0, both_cnt = 0;
    int exp_msg = 0, exp_err = 0;

    order_msg_parser #(.ADD_TYPE(8'h41), .CXL_TYPE(8'h58), .WAIT_MAX(16'(WMAX))) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ord_id(ord_id), .ord_side(ord_side),
        .ord_price(ord_price), .ord_qty(ord_qty), .add_start(add_start),
        .cxl_start(cxl_start), .done_in(done_in), .msg_count(msg_count),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (add_start) add_cnt++;
        if (cxl_start) cxl_cnt++;
        if (add_start && cxl_start) both_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        if (!in_ready) begin
            chk++; fail++;
            $display("FAIL byte_accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
    endtask

    // Sends 8 bytes; returns at the negedge right after byte7 transfers.
    task automatic send_msg(input logic [63:0] m, input int gap_mode);
        logic [48:0] snap;
        int g;
        snap = {ord_id, ord_side, ord_price, ord_qty};
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                chk++;
                if ({ord_id, ord_side, ord_price, ord_qty} !== snap) begin
                    fail++;
                    $display("FAIL ord_stable_collect: got %h required %h",
                             {ord_id, ord_side, ord_price, ord_qty}, snap);
                end
            end
            g = (i == 0) ? 0 : (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            send_byte(m[63-8*i -: 8], g);
        end
        in_valid = 1'b0;
    endtask

    // Full transaction against the reference model. d = WAIT cycle in which
    // done_in is driven (0 = during DISPATCH, >WMAX = after timeout).
    task automatic run_msg(input logic [63:0] m, input int gap_mode, input int d);
        int a0, c0, wcyc, exp_w;
        logic [7:0] typ;
        bit ok_type, is_add, success;
        typ     = m[63:56];
        is_add  = (typ == 8'h41);
        ok_type = is_add || (typ == 8'h58);
        success = ok_type && d >= 1 && d <= WMAX;
        a0 = add_cnt; c0 = cxl_cnt;
        send_msg(m, gap_mode);
        if (ok_type) begin
            chk++;
            if ({add_start, cxl_start} !== {is_add, !is_add}) begin
                fail++;
                $display("FAIL start_latency: add/cxl=%b%b required %b%b",
                         add_start, cxl_start, is_add, !is_add);
            end
            chk++;
            if ({ord_id, ord_side, ord_price, ord_qty} !== {m[55:40], m[32], m[31:16], m[15:0]}) begin
                fail++;
                $display("FAIL fields: got %h/%b/%h/%h required %h/%b/%h/%h", ord_id, ord_side,
                         ord_price, ord_qty, m[55:40], m[32], m[31:16], m[15:0]);
            end
            exp_msg++;
            if (!success) exp_err++;
            done_in = (d == 0);
            wcyc = 0;
            for (int j = 1; j <= WMAX + 2; j++) begin
                @(negedge clk);
                done_in = (j == d);
                if (busy) wcyc++;
                if (j == d && success) begin
                    chk++;
                    if ({busy, ord_id, ord_side, ord_price, ord_qty} !==
                        {1'b1, m[55:40], m[32], m[31:16], m[15:0]}) begin
                        fail++;
                        $display("FAIL ord_hold_wait: busy=%b id=%h required busy=1 id=%h",
                                 busy, ord_id, m[55:40]);
                    end
                end
                if (j == d + 1 && success) begin
                    chk++;
                    if ({busy, in_ready} !== 2'b01) begin
                        fail++;
                        $display("FAIL idle_after_done: busy/in_ready=%b%b required 01", busy, in_ready);
                    end
                end
            end
            done_in = 1'b0;
            exp_w = success ? d : WMAX;
            chk++;
            if (wcyc != exp_w) begin
                fail++;
                $display("FAIL wait_len: got %0d required %0d", wcyc, exp_w);
            end
        end else begin
            chk++;
            if ({add_start, cxl_start, busy} !== 3'b000) begin
                fail++;
                $display("FAIL drop_no_start: add/cxl/busy=%b%b%b required 000",
                         add_start, cxl_start, busy);
            end
            exp_err++;
            @(negedge clk);
        end
        chk++;
        if (msg_count !== 16'(exp_msg) || err_count !== 16'(exp_err)) begin
            fail++;
            $display("FAIL counters: msg=%0d err=%0d required msg=%0d err=%0d",
                     msg_count, err_count, exp_msg, exp_err);
        end
        chk++;
        if (add_cnt - a0 != int'(ok_type && is_add) || cxl_cnt - c0 != int'(ok_type && !is_add)
            || both_cnt != 0) begin
            fail++;
            $display("FAIL pulse_count: add=%0d cxl=%0d both=%0d required add=%0d cxl=%0d both=0",
                     add_cnt - a0, cxl_cnt - c0, both_cnt, int'(ok_type && is_add),
                     int'(ok_type && !is_add));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; done_in = 1'b0;
        repeat (2) @(negedge clk);
        chk++;
        if ({in_ready, busy, add_start, cxl_start, ord_id, ord_side, ord_price, ord_qty,
             msg_count, err_count} !== '0) begin
            fail++;
            $display("FAIL reset_vals: rdy=%b busy=%b id=%h price=%h qty=%h msg=%0d err=%0d required all 0",
                     in_ready, busy, ord_id, ord_price, ord_qty, msg_count, err_count);
        end
        rst_n = 1'b1;
        exp_msg = 0; exp_err = 0;
        @(negedge clk);
        chk++;
        if ({in_ready, busy} !== 2'b10) begin
            fail++;
            $display("FAIL ready_after_reset: rdy/busy=%b%b required 10", in_ready, busy);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_add();
        run_msg(64'h41_00_07_01_03_E8_00_64, 0, 3);
    endtask

    task automatic test_cancel();
        run_msg(64'h58_00_07_00_00_00_00_00, 0, 2);
    endtask

    task automatic test_unknown();
        run_msg({8'h5A, 24'($urandom), 32'($urandom)}, 0, 0);
        run_msg(64'h41_12_34_01_0A_BC_00_FF, 0, 1);
    endtask

    task automatic test_valid_toggle();
        run_msg(64'h41_00_07_01_03_E8_00_64, 1, 4);
    endtask

    task automatic test_timeout();
        apply_reset();
        run_msg(64'h41_00_07_01_03_E8_00_64, 0, WMAX + 1);
        chk++;
        if (msg_count !== 16'd1 || err_count !== 16'd1) begin
            fail++;
            $display("FAIL timeout_counts: msg=%0d err=%0d required 1/1", msg_count, err_count);
        end
    endtask

    task automatic test_boundary();
        run_msg(64'h58_AB_CD_01_11_22_33_44, 0, WMAX);
        run_msg(64'h41_00_01_00_00_02_00_03, 2, 0);
    endtask

    task automatic test_mid_reset();
        logic [63:0] m;
        m = 64'h41_55_66_01_77_88_99_AA;
        for (int i = 0; i < 5; i++) send_byte(m[63-8*i -: 8], 0);
        in_valid = 1'b0;
        apply_reset();
        run_msg(64'h41_00_07_01_03_E8_00_64, 0, 3);
        chk++;
        if (msg_count !== 16'd1 || err_count !== 16'd0) begin
            fail++;
            $display("FAIL mid_reset_counts: msg=%0d err=%0d required 1/0", msg_count, err_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] typ;
        int sel;
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      typ = 8'h41;
            else if (sel < 8) typ = 8'h58;
            else begin
                typ = 8'($urandom);
                while (typ == 8'h41 || typ == 8'h58) typ = 8'($urandom);
            end
            run_msg({typ, 24'($urandom), 32'($urandom)}, $urandom_range(0, 2),
                    $urandom_range(0, WMAX + 1));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cancel();
        test_unknown();
        test_valid_toggle();
        test_boundary();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", chk - fail, chk);
        $finish;
    end

endmodule
